// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-line memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_RESP,
    ARB_DONE
  } arb_state_t;

  localparam int DEFAULT_LINE_WIDTH = 1024;
  localparam int LINE_BYTES         = DEFAULT_LINE_WIDTH / 8;
  localparam int LINE_OFFSET_BITS   = $clog2(LINE_BYTES);

  localparam int REQ_DCACHE = 0;
  localparam int REQ_ICACHE = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester strictly after 'last', wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && valid[(int'(last) + k) % N]) begin
        found                          = 1'b1;
        grant[(int'(last) + k) % N]    = 1'b1;
        idx                            = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single line-sized bus engine between dcache (0) and icache (1).
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_store,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LINE_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [LINE_WIDTH-1:0]       rsp_rdata,
  output logic                        rsp_err,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_store,
  output logic [ADDR_WIDTH-1:0]       cmd_addr,
  output logic [LINE_WIDTH-1:0]       cmd_wdata,
  input  logic                        bus_done,
  input  logic [LINE_WIDTH-1:0]       bus_rdata,
  input  logic                        inv_valid,
  output logic                        busy
);

  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int OffBits = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = {ADDR_WIDTH{1'b1}} << OffBits;

  arb_state_t       state, state_next;
  logic [IW-1:0]    last;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_grant;
  logic             start;
  logic             timed_out;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // A pending snoop invalidate only holds off the next pick, never an active transaction.
  assign start = (state == ARB_IDLE) && !inv_valid && (|req_valid);

`ifdef ARB_TIMEOUT_EN
  localparam int CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] wait_cnt;

  // Timeout fires on the edge where the count would reach TIMEOUT-1; bus_done wins a tie.
  assign timed_out = (state == ARB_WAIT_RESP) && !bus_done &&
                     (wait_cnt == CntW'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == ARB_ISSUE && cmd_ready) wait_cnt <= '0;
      else if (state == ARB_WAIT_RESP && !bus_done) wait_cnt <= wait_cnt + 1'b1;
      if (state == ARB_WAIT_RESP && bus_done) rsp_err <= 1'b0;
      else if (timed_out) rsp_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:      if (start) state_next = ARB_ISSUE;
      ARB_ISSUE:     if (cmd_ready) state_next = ARB_WAIT_RESP;
      ARB_WAIT_RESP: if (bus_done || timed_out) state_next = ARB_DONE;
      ARB_DONE:      state_next = ARB_IDLE;
      default:       state_next = ARB_IDLE;
    endcase
  end

  assign cmd_valid = (state == ARB_ISSUE);
  assign busy      = (state != ARB_IDLE);
  assign rsp_valid = (state == ARB_DONE) ? grant : '0;

  // Owner fields are captured once at the pick and frozen for the whole transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant     <= '0;
      last      <= IW'(N_REQ - 1);
      cmd_store <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      if (start) begin
        grant     <= pick_grant;
        last      <= pick_idx;
        cmd_store <= req_store[pick_idx];
        cmd_addr  <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH] & AddrMask;
        cmd_wdata <= req_wdata[int'(pick_idx)*LINE_WIDTH +: LINE_WIDTH];
      end
      if (state == ARB_WAIT_RESP && bus_done) rsp_rdata <= bus_rdata;
      else if (timed_out)                     rsp_rdata <= '0;
      if (state == ARB_DONE) grant <= '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; the bench plays both caches and the bus engine.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int LW = 1024;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_store = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_wdata = '0;
  logic [N-1:0]    grant, rsp_valid;
  logic [LW-1:0]   rsp_rdata, cmd_wdata;
  logic            rsp_err, cmd_valid, cmd_store, busy;
  logic            cmd_ready = 1'b0;
  logic [AW-1:0]   cmd_addr;
  logic            bus_done = 1'b0;
  logic [LW-1:0]   bus_rdata = '0;
  logic            inv_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_store(cmd_store), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .bus_done(bus_done),
    .bus_rdata(bus_rdata), .inv_valid(inv_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    logic          store;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } cmd_exp_t;

  typedef struct {
    logic [N-1:0]  rsp;
    logic [LW-1:0] rdata;
    logic          err;
  } rsp_exp_t;

  typedef struct {
    bit            seen_cmd;
    int            lat;
    logic [N-1:0]  grant;
    logic          store;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit            stable;
    bit            seen_rsp;
    int            rsp_cycle;
    logic [N-1:0]  rsp;
    logic [LW-1:0] rdata;
    logic          err;
    logic [N-1:0]  rsp_after;
  } obs_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];

  function automatic logic [LW-1:0] pattern(input logic [7:0] b);
    return {(LW/8){b}};
  endfunction

  // Bus-engine side of one transaction; observations only, the tests judge them.
  task automatic applyStimulus(input int ready_delay, input bit give_done,
                               input logic [LW-1:0] rdata, input bit drop, output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    for (int i = 1; i <= 20 && !o.seen_cmd; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) begin
        o.seen_cmd = 1'b1;
        o.lat = i;
      end
    end
    if (!o.seen_cmd) return;
    o.grant = grant; o.store = cmd_store; o.addr = cmd_addr; o.wdata = cmd_wdata;
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_addr !== o.addr || cmd_wdata !== o.wdata ||
          cmd_store !== o.store || grant !== o.grant) o.stable = 1'b0;
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    for (int idx = 1; idx <= 40 && !o.seen_rsp; idx++) begin
      if (rsp_valid !== '0) begin
        o.seen_rsp = 1'b1; o.rsp_cycle = idx;
        o.rsp = rsp_valid; o.rdata = rsp_rdata; o.err = rsp_err;
      end else begin
        bus_done  = give_done && (idx == 3);
        bus_rdata = bus_done ? rdata : '0;
        @(negedge clk);
      end
    end
    bus_done = 1'b0;
    bus_rdata = '0;
    if (drop) req_valid = req_valid & ~o.rsp;
    @(negedge clk);
    o.rsp_after = rsp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (grant !== '0 || rsp_valid !== '0) begin errors++;
      $display("[TB] FAIL reset_grant_rsp: got %b/%b expected 00/00", grant, rsp_valid); end
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || rsp_err !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_ctrl: got cmd_valid=%b busy=%b err=%b expected 0", cmd_valid, busy, rsp_err); end
    checks++; if (cmd_addr !== '0 || rsp_rdata !== '0) begin errors++;
      $display("[TB] FAIL reset_data: got addr=%h rdata_lo=%h expected 0", cmd_addr, rsp_rdata[63:0]); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_fill();
    obs_t o;
    cmd_exp_t ce;
    rsp_exp_t re;
    req_addr[AW-1:0] = 64'h8000_1234;
    req_store = 2'b00;
    req_wdata = '0;
    req_valid = 2'b01;
    cmd_q.push_back('{2'b01, 1'b0, 64'h8000_1200, '0});
    rsp_q.push_back('{2'b01, pattern(8'hA5), 1'b0});
    applyStimulus(3, 1'b1, pattern(8'hA5), 1'b1, o);
    ce = cmd_q.pop_front();
    re = rsp_q.pop_front();
    checks++; if (!o.seen_cmd || o.lat != 1) begin errors++;
      $display("[TB] FAIL fill_latency: got seen=%0d lat=%0d expected 1/1", o.seen_cmd, o.lat); end
    checks++; if (o.addr !== ce.addr || o.store !== ce.store || o.grant !== ce.grant) begin errors++;
      $display("[TB] FAIL fill_cmd: got addr=%h st=%b g=%b expected %h/%b/%b", o.addr, o.store, o.grant, ce.addr, ce.store, ce.grant); end
    checks++; if (o.rsp !== re.rsp || o.rdata !== re.rdata || o.err !== re.err) begin errors++;
      $display("[TB] FAIL fill_rsp: got rsp=%b rdata_lo=%h err=%b expected %b/%h/%b", o.rsp, o.rdata[63:0], o.err, re.rsp, re.rdata[63:0], re.err); end
    checks++; if (o.rsp_after !== 2'b00) begin errors++;
      $display("[TB] FAIL fill_rsp_pulse: got %b expected 00", o.rsp_after); end
  endtask

  task automatic test_round_robin();
    obs_t o;
    cmd_exp_t ce;
    rsp_exp_t re;
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    req_addr  = {64'h2000_00C0, 64'h1000_0040};
    req_store = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cmd_q.push_back('{(k == 1) ? 2'b10 : 2'b01, 1'b0,
                        (k == 1) ? 64'h2000_0080 : 64'h1000_0000, '0});
      rsp_q.push_back('{(k == 1) ? 2'b10 : 2'b01, pattern(8'(8'h10 + k)), 1'b0});
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1'b1, pattern(8'(8'h10 + k)), 1'b0, o);
      ce = cmd_q.pop_front();
      re = rsp_q.pop_front();
      checks++; if (o.grant !== ce.grant || o.addr !== ce.addr) begin errors++;
        $display("[TB] FAIL rr_grant%0d: got g=%b addr=%h expected %b/%h", k, o.grant, o.addr, ce.grant, ce.addr); end
      checks++; if (o.rsp !== re.rsp || o.rdata !== re.rdata) begin errors++;
        $display("[TB] FAIL rr_rsp%0d: got %b/%h expected %b/%h", k, o.rsp, o.rdata[63:0], re.rsp, re.rdata[63:0]); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_inv_gate();
    obs_t o;
    cmd_exp_t ce;
    bit leaked = 1'b0;
    req_addr[2*AW-1:AW] = 64'h3333_3355;
    inv_valid = 1'b1;
    req_valid = 2'b10;
    cmd_q.push_back('{2'b10, 1'b0, 64'h3333_3300, '0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
    end
    checks++; if (leaked) begin errors++;
      $display("[TB] FAIL inv_block: got issue during invalidate expected none"); end
    inv_valid = 1'b0;
    applyStimulus(0, 1'b1, pattern(8'h3C), 1'b1, o);
    ce = cmd_q.pop_front();
    checks++; if (o.lat != 1 || o.grant !== ce.grant || o.addr !== ce.addr) begin errors++;
      $display("[TB] FAIL inv_release: got lat=%0d g=%b addr=%h expected 1/%b/%h", o.lat, o.grant, o.addr, ce.grant, ce.addr); end
  endtask

  task automatic test_store_hold();
    obs_t o;
    cmd_exp_t ce;
    logic [LW-1:0] wd;
    for (int i = 0; i < LW/32; i++) wd[i*32 +: 32] = $urandom;
    wd[31:0] = 32'hDEAD_BEEF;
    req_wdata[2*LW-1:LW] = wd;
    req_store = 2'b10;
    req_addr[2*AW-1:AW] = 64'h4444_44FF;
    req_valid = 2'b10;
    cmd_q.push_back('{2'b10, 1'b1, 64'h4444_4480, wd});
    applyStimulus(4, 1'b1, pattern(8'h77), 1'b1, o);
    ce = cmd_q.pop_front();
    checks++; if (o.store !== ce.store || o.wdata !== ce.wdata || o.addr !== ce.addr) begin errors++;
      $display("[TB] FAIL store_cmd: got st=%b wd_lo=%h addr=%h expected %b/%h/%h", o.store, o.wdata[63:0], o.addr, ce.store, ce.wdata[63:0], ce.addr); end
    checks++; if (!o.stable) begin errors++;
      $display("[TB] FAIL store_stable: got fields changing expected stable"); end
    checks++; if (o.rsp !== 2'b10) begin errors++;
      $display("[TB] FAIL store_rsp: got %b expected 10", o.rsp); end
    req_store = 2'b00;
  endtask

  task automatic test_reset_inflight();
    obs_t o;
    cmd_exp_t ce;
    bit seen = 1'b0;
    req_addr[AW-1:0] = 64'h5555_0100;
    req_valid = 2'b01;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (cmd_valid === 1'b1);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    checks++; if (!seen || busy !== 1'b1 || cmd_valid !== 1'b0) begin errors++;
      $display("[TB] FAIL inflight_wait: got seen=%0d busy=%b cmd_valid=%b expected 1/1/0", seen, busy, cmd_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (grant !== '0 || busy !== 1'b0 || cmd_valid !== 1'b0 || rsp_valid !== '0) begin errors++;
      $display("[TB] FAIL async_reset_ctrl: got g=%b busy=%b cv=%b rv=%b expected 0", grant, busy, cmd_valid, rsp_valid); end
    checks++; if (cmd_addr !== '0 || cmd_wdata !== '0 || rsp_rdata !== '0 || cmd_store !== 1'b0) begin errors++;
      $display("[TB] FAIL async_reset_data: got addr=%h rdata_lo=%h expected 0", cmd_addr, rsp_rdata[63:0]); end
    req_valid = 2'b11;
    @(negedge clk);
    reset = 1'b1;
    cmd_q.push_back('{2'b01, 1'b0, 64'h5555_0100, '0});
    applyStimulus(0, 1'b1, pattern(8'h5A), 1'b0, o);
    ce = cmd_q.pop_front();
    checks++; if (o.lat != 1 || o.grant !== ce.grant) begin errors++;
      $display("[TB] FAIL post_reset_grant: got lat=%0d g=%b expected 1/%b", o.lat, o.grant, ce.grant); end
    req_valid = 2'b00;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    rsp_exp_t re;
    req_valid = 2'b01;
    rsp_q.push_back('{2'b01, '0, 1'b1});
    applyStimulus(0, 1'b0, '0, 1'b1, o);
    re = rsp_q.pop_front();
    checks++; if (!o.seen_rsp || o.rsp_cycle != TO) begin errors++;
      $display("[TB] FAIL timeout_cycle: got seen=%0d cycle=%0d expected 1/%0d", o.seen_rsp, o.rsp_cycle, TO); end
    checks++; if (o.rsp !== re.rsp || o.err !== re.err || o.rdata !== re.rdata) begin errors++;
      $display("[TB] FAIL timeout_rsp: got %b/%b/%h expected %b/%b/%h", o.rsp, o.err, o.rdata[63:0], re.rsp, re.err, re.rdata[63:0]); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_round_robin();
    test_inv_gate();
    test_store_hold();
    test_reset_inflight();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single cache-line bus engine between the data cache (requester 0) and the instruction cache (requester 1).
- Sits between both directCache command interfaces and the AXI bus engine.
- Sequences one line-sized fill or writeback at a time, using round-robin grant and a 4-state FSM.
- Blocks new issue while a snoop invalidate is in progress.

Parameters:
N_REQ, 2, number of requesters (index 0 = data cache, 1 = instruction cache)
ADDR_WIDTH, 64, address width
LINE_WIDTH, 1024, cache line width in bits (DATA_WIDTH*16)
TIMEOUT, 1024, response watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester command request; held until that requester's rsp_valid
req_store  in  N_REQ  1 = line writeback, 0 = line fill
req_addr  in  N_REQ*ADDR_WIDTH  packed request addresses
req_wdata  in  N_REQ*LINE_WIDTH  packed writeback line data
grant  out  N_REQ  one-hot owner of current transaction
rsp_valid  out  N_REQ  one-cycle completion pulse to the owner
rsp_rdata  out  LINE_WIDTH  fill data, shared by all requesters
rsp_err  out  1  completion was a timeout
cmd_valid  out  1  command to bus engine
cmd_ready  in  1  bus engine accepts command
cmd_store  out  1  registered copy of owner req_store
cmd_addr  out  ADDR_WIDTH  owner address with low log2(LINE_WIDTH/8) bits zeroed
cmd_wdata  out  LINE_WIDTH  owner write line
bus_done  in  1  bus engine finished transaction
bus_rdata  in  LINE_WIDTH  fill line, valid with bus_done
inv_valid  in  1  snoop invalidate active
busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0 and state goes to IDLE.
  - RR pointer last goes to N_REQ-1, so requester 0 wins first.
  - Any in-flight transaction is abandoned; the bus engine is reset by the same reset.
- FSM IDLE -> ISSUE -> WAIT_RESP -> DONE -> IDLE.
- IDLE:
  - Stays while inv_valid=1 or req_valid=0.
  - Otherwise picks the first valid requester after last (wrapping).
  - Registers grant, cmd_store, aligned cmd_addr and cmd_wdata; updates last; asserts cmd_valid next cycle.
  - Request-to-cmd_valid latency: 1 cycle.
- ISSUE:
  - cmd_valid=1 and cmd_* fields held stable until cmd_ready=1.
  - On cmd_ready=1: cmd_valid drops next cycle; go to WAIT_RESP.
- WAIT_RESP: on bus_done=1, capture bus_rdata into rsp_rdata and go to DONE. bus_done is ignored in any other state.
- DONE:
  - rsp_valid[owner]=1 for exactly one cycle; grant is cleared on exit.
  - Requester must drop req_valid on the cycle after rsp_valid, otherwise it is treated as a new request.
- busy=1 in ISSUE, WAIT_RESP and DONE.
- Store completions: rsp_rdata holds bus_rdata as delivered; requesters ignore it.
- Grant fields are not re-sampled after IDLE; requester changes mid-transaction are ignored.
- inv_valid rising while in ISSUE/WAIT_RESP does not abort the transaction; it only gates the next IDLE pick.
- Fairness: two persistent requesters alternate grants; worst-case wait is one transaction.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on WAIT_RESP entry and increments each cycle without bus_done.
  - When it reaches TIMEOUT-1, go to DONE with rsp_err=1 and rsp_rdata=0.
  - bus_done in that same cycle wins (normal completion, rsp_err=0).
- Undefined: WAIT_RESP waits indefinitely; rsp_err is tied 0; no counter is instantiated.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RESP, ARB_DONE}
  - constants LINE_BYTES, LINE_OFFSET_BITS
  - requester index constants REQ_DCACHE=0, REQ_ICACHE=1
- Sub-module rr_pick: combinational round-robin picker, inputs valid vector and last, outputs one-hot grant and index.

Test Plan:
1. req_valid=01, req_store=0, req_addr[0]=0x8000_1234 -> cmd_valid next cycle, cmd_addr=0x8000_1200, cmd_store=0; cmd_ready after 3 cycles; bus_done with rdata=0xA5 pattern -> rsp_valid=01 for one cycle, rsp_rdata=pattern.
2. From reset, req_valid=11 held through two completions -> first grant=01, second grant=10, third grant=01.
3. inv_valid=1 for 5 cycles with req_valid=10 -> cmd_valid stays 0 throughout; cmd_valid=1 the cycle after inv_valid falls.
4. req_store[1]=1, req_wdata[1]=0x...DEADBEEF -> cmd_store=1, cmd_wdata equals it; cmd_wdata stable while cmd_ready held 0 for 4 cycles.
5. reset=0 asserted in WAIT_RESP -> all outputs 0 without a clock edge; after release, req_valid=11 -> grant=01.
6. ARB_TIMEOUT_EN, TIMEOUT=16, no bus_done -> rsp_valid and rsp_err=1, rsp_rdata=0 on the 16th cycle after WAIT_RESP entry.
